// File: rtl/button_conditioner_pkg.sv
// Shared constants for the set-button conditioner: FSM encodings and default timing.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    BC_IDLE    = 2'd0,
    BC_PRESSED = 2'd1,
    BC_REPEAT  = 2'd2
  } bc_state_e;

  localparam int BC_DEBOUNCE_CYCLES = 16;
  localparam int BC_REPEAT_DELAY    = 64;
  localparam int BC_REPEAT_RATE     = 16;
  localparam int BC_REPEAT_EN       = 1;
  localparam int BC_CNT_W           = 8;

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, held flop,
// press/repeat FSM and repeat counter.
//   state      | meaning
//   BC_IDLE    | button released, waiting for debounced rising edge
//   BC_PRESSED | press pulse issued, timing the initial repeat delay
//   BC_REPEAT  | auto-repeating at REPEAT_RATE while held
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BC_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = BC_REPEAT_DELAY,
  parameter int REPEAT_RATE     = BC_REPEAT_RATE,
  parameter int REPEAT_EN       = BC_REPEAT_EN,
  parameter int CNT_W           = BC_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic pulse_o,
  output logic held_o
);

  localparam int MAX_CNT = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                         ? ((DEBOUNCE_CYCLES > REPEAT_RATE) ? DEBOUNCE_CYCLES : REPEAT_RATE)
                         : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

  generate
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        CNT_W < 1 || CNT_W > 30 || (2 ** CNT_W) <= MAX_CNT) begin : g_bad_params
      $error("btn_channel: timing parameters out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic             s1_q, s2_q;
  logic             held_q, held_d;
  logic             pulse_q;
  logic             db_flip;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rp_cnt_q;
  bc_state_e        state_q;

  always_comb begin
    db_flip  = (s2_q != held_q) && (db_cnt_q == DB_LAST);
    held_d   = held_q ^ db_flip;
    db_cnt_d = ((s2_q == held_q) || db_flip) ? '0 : db_cnt_q + 1'b1;
  end

  // The FSM looks at held_d so the press pulse lands in the same cycle held rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      held_q   <= 1'b0;
      db_cnt_q <= '0;
      rp_cnt_q <= '0;
      pulse_q  <= 1'b0;
      state_q  <= BC_IDLE;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      held_q   <= held_d;
      db_cnt_q <= db_cnt_d;
      pulse_q  <= 1'b0;
      case (state_q)
        BC_IDLE: begin
          if (held_d) begin
            state_q  <= BC_PRESSED;
            pulse_q  <= 1'b1;
            rp_cnt_q <= '0;
          end
        end
        BC_PRESSED: begin
          if (!held_d) begin
            state_q  <= BC_IDLE;
            rp_cnt_q <= '0;
          end else if (rp_cnt_q == RD_LAST) begin
            // Without auto-repeat the counter parks at its terminal value.
            if (REPEAT_EN != 0) begin
              state_q  <= BC_REPEAT;
              pulse_q  <= 1'b1;
              rp_cnt_q <= '0;
            end
          end else begin
            rp_cnt_q <= rp_cnt_q + 1'b1;
          end
        end
        BC_REPEAT: begin
          if (!held_d) begin
            state_q  <= BC_IDLE;
            rp_cnt_q <= '0;
          end else if (rp_cnt_q == RR_LAST) begin
            pulse_q  <= 1'b1;
            rp_cnt_q <= '0;
          end else begin
            rp_cnt_q <= rp_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= BC_IDLE;
          rp_cnt_q <= '0;
        end
      endcase
    end
  end

  assign pulse_o = pulse_q;
  assign held_o  = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Minute/hour set-button conditioner: two independent, identical button channels.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BC_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = BC_REPEAT_DELAY,
  parameter int REPEAT_RATE     = BC_REPEAT_RATE,
  parameter int REPEAT_EN       = BC_REPEAT_EN,
  parameter int CNT_W           = BC_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic min_raw,
  input  logic hour_raw,
  output logic min_pulse,
  output logic hour_pulse,
  output logic min_held,
  output logic hour_held
);

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE),
    .REPEAT_EN      (REPEAT_EN),
    .CNT_W          (CNT_W)
  ) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (min_raw),
    .pulse_o(min_pulse),
    .held_o (min_held)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE),
    .REPEAT_EN      (REPEAT_EN),
    .CNT_W          (CNT_W)
  ) u_hour (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (hour_raw),
    .pulse_o(hour_pulse),
    .held_o (hour_held)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE=4, DELAY=10, RATE=3), with a
// second instance built without auto-repeat.
module tb_button_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, min_raw, hour_raw;
  logic min_pulse, hour_pulse, min_held, hour_held;
  logic min_pulse_nr, hour_pulse_nr, min_held_nr, hour_held_nr;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .REPEAT_EN(1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .min_raw(min_raw), .hour_raw(hour_raw),
    .min_pulse(min_pulse), .hour_pulse(hour_pulse),
    .min_held(min_held), .hour_held(hour_held)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .REPEAT_EN(0), .CNT_W(8)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .min_raw(min_raw), .hour_raw(hour_raw),
    .min_pulse(min_pulse_nr), .hour_pulse(hour_pulse_nr),
    .min_held(min_held_nr), .hour_held(hour_held_nr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-test log; index t is the cycle whose raw inputs are driven at negedge t,
  // so outputs logged at index t reflect posedge t-1.
  int         t;
  int         mp_at[$], hp_at[$], mp_nr_at[$];
  int         mh_n, hh_n, both_n, consec_n;
  logic [3:0] out_log[$];
  logic       prev_mp, prev_hp;

  task automatic clear_log();
    t = 0;
    mp_at.delete(); hp_at.delete(); mp_nr_at.delete(); out_log.delete();
    mh_n = 0; hh_n = 0; both_n = 0; consec_n = 0;
    prev_mp = 1'b0; prev_hp = 1'b0;
  endtask

  task automatic tick(input logic m, input logic h, input logic r);
    @(negedge clk);
    if (min_pulse === 1'b1)    mp_at.push_back(t);
    if (hour_pulse === 1'b1)   hp_at.push_back(t);
    if (min_pulse_nr === 1'b1) mp_nr_at.push_back(t);
    if (min_held === 1'b1)     mh_n++;
    if (hour_held === 1'b1)    hh_n++;
    if (min_pulse === 1'b1 && hour_pulse === 1'b1) both_n++;
    if ((min_pulse === 1'b1 && prev_mp === 1'b1) || (hour_pulse === 1'b1 && prev_hp === 1'b1))
      consec_n++;
    prev_mp = min_pulse;
    prev_hp = hour_pulse;
    out_log.push_back({min_pulse, hour_pulse, min_held, hour_held});
    min_raw  = m;
    hour_raw = h;
    rst_n    = r;
    t++;
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  int rep_off[8] = '{0, 10, 13, 16, 19, 22, 25, 28};
  int sim_pos[5] = '{6, 16, 19, 22, 25};
  int bounce[6]  = '{1, 0, 1, 1, 0, 1};

  initial begin
    rst_n = 1'b0; min_raw = 1'b0; hour_raw = 1'b0;
    clear_log();

    // Reset
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("reset_outs", int'(out_log[4]), 0);
    check("reset_outs_nr", int'({min_pulse_nr, hour_pulse_nr, min_held_nr, hour_held_nr}), 0);
    repeat (5) tick(1'b0, 1'b0, 1'b1);

    // 1. Clean press, 8 cycles
    clear_log();
    repeat (8)  tick(1'b1, 1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 1'b1);
    check("clean_pulse_cnt", mp_at.size(), 1);
    check("clean_pulse_pos", at(mp_at, 0), 6);
    check("clean_held_len", mh_n, 8);
    check("clean_hour_pulse", hp_at.size(), 0);
    check("clean_hour_held", hh_n, 0);

    // 2. Bounce on hour, final stable high from index 5
    clear_log();
    for (int i = 0; i < 6; i++) tick(1'b0, bounce[i][0], 1'b1);
    repeat (7)  tick(1'b0, 1'b1, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 1'b1);
    check("bounce_pulse_cnt", hp_at.size(), 1);
    check("bounce_pulse_pos", at(hp_at, 0), 11);
    check("bounce_min_pulse", mp_at.size(), 0);

    // 3. Auto-repeat: held 30 cycles past the press pulse
    clear_log();
    repeat (30) tick(1'b1, 1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 1'b1);
    check("rep_cnt", mp_at.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("rep_pos%0d", i), at(mp_at, i), 6 + rep_off[i]);
    check("rep_no_consec", consec_n, 0);
    check("norep_cnt", mp_nr_at.size(), 1);
    check("norep_pos", at(mp_nr_at, 0), 6);

    // 4. Simultaneous press
    clear_log();
    repeat (20) tick(1'b1, 1'b1, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 1'b1);
    check("sim_min_cnt", mp_at.size(), 5);
    check("sim_hour_cnt", hp_at.size(), 5);
    check("sim_both_cnt", both_n, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sim_min_pos%0d", i), at(mp_at, i), sim_pos[i]);
      check($sformatf("sim_hour_pos%0d", i), at(hp_at, i), sim_pos[i]);
    end

    // 5. Reset mid-press, 2 cycles after the press pulse
    clear_log();
    repeat (8)  tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    repeat (9)  tick(1'b1, 1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 1'b1);
    check("rst_held_before", int'(out_log[8][1]), 1);
    check("rst_outs_cleared", int'(out_log[9]), 0);
    check("rst_pulse_cnt", mp_at.size(), 2);
    check("rst_first_pulse", at(mp_at, 0), 6);
    check("rst_repress_pos", at(mp_at, 1), 15);

    // 6. Short glitch
    clear_log();
    repeat (3)  tick(1'b1, 1'b0, 1'b1);
    repeat (15) tick(1'b0, 1'b0, 1'b1);
    check("glitch_pulse_cnt", mp_at.size(), 0);
    check("glitch_held", mh_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
